// File: rtl/bf_exec_ctrl.sv
// BF CPU instruction sequencer: fetch/execute loop, I/O handshakes and bracket
// scanning over a synchronous instruction ROM with a nesting-depth counter.
module bf_exec_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  input  logic              inc_dp,
  input  logic              dec_dp,
  input  logic              inc_d,
  input  logic              dec_d,
  input  logic              out_d,
  input  logic              in_d,
  input  logic              loop_start,
  input  logic              loop_end,
  input  logic              nop,
  input  logic              d_zero,
  output logic              dp_inc,
  output logic              dp_dec,
  output logic              d_inc,
  output logic              d_dec,
  output logic              d_load,
  output logic              in_req,
  input  logic              in_ack,
  output logic              out_req,
  input  logic              out_ack,
  output logic              halted,
  output logic              error
);

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_SFETCH   = 3'd2;
  localparam logic [2:0] S_SCHECK   = 3'd3;
  localparam logic [2:0] S_WAIT_IN  = 3'd4;
  localparam logic [2:0] S_WAIT_OUT = 3'd5;
  localparam logic [2:0] S_HALT     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  logic [2:0]         state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic               back_reg, back_next;

  logic       advance;
  logic       retreat;
  logic [2:0] adv_state;
  logic       is_zero;
  logic       exec_op;

  assign is_zero = (imem_data == 8'h00);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    depth_next = depth_reg;
    back_next  = back_reg;
    advance    = 1'b0;
    retreat    = 1'b0;
    adv_state  = S_FETCH;
    case (state_reg)
      S_FETCH: if (run) state_next = S_EXEC;
      S_EXEC: begin
        if (is_zero) begin
          state_next = S_HALT;
        end else if (loop_start) begin
          advance = 1'b1;
          if (d_zero) begin
            back_next  = 1'b0;
            depth_next = '0;
            adv_state  = S_SFETCH;
          end
        end else if (loop_end) begin
          if (!d_zero) begin
            back_next  = 1'b1;
            depth_next = '0;
            retreat    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else if (in_d) begin
          state_next = S_WAIT_IN;
        end else if (out_d) begin
          state_next = S_WAIT_OUT;
        end else if (inc_dp | dec_dp | inc_d | dec_d | nop) begin
          advance = 1'b1;
        end else begin
          // a non-zero byte the decoder did not classify at all
          state_next = S_ERROR;
        end
      end
      S_WAIT_IN:  if (in_ack)  advance = 1'b1;
      S_WAIT_OUT: if (out_ack) advance = 1'b1;
      S_SFETCH:   state_next = S_SCHECK;
      S_SCHECK: begin
        if (!back_reg) begin
          if (is_zero) begin
            state_next = S_ERROR;
          end else if (loop_start) begin
            if (&depth_reg) state_next = S_ERROR;
            else begin
              depth_next = depth_reg + 1'b1;
              advance    = 1'b1;
              adv_state  = S_SFETCH;
            end
          end else if (loop_end && depth_reg == '0) begin
            advance = 1'b1;
          end else begin
            if (loop_end) depth_next = depth_reg - 1'b1;
            advance   = 1'b1;
            adv_state = S_SFETCH;
          end
        end else begin
          if (loop_end) begin
            if (&depth_reg) state_next = S_ERROR;
            else begin
              depth_next = depth_reg + 1'b1;
              retreat    = 1'b1;
            end
          end else if (loop_start && depth_reg == '0) begin
            // resume on the byte just after the matching '['
            advance = 1'b1;
          end else begin
            if (loop_start) depth_next = depth_reg - 1'b1;
            retreat = 1'b1;
          end
        end
      end
      default: state_next = state_reg;
    endcase

    // pc never wraps in either direction; running off an end is fatal
    if (advance) begin
      if (&pc_reg) state_next = S_ERROR;
      else begin
        pc_next    = pc_reg + 1'b1;
        state_next = adv_state;
      end
    end else if (retreat) begin
      if (pc_reg == '0) state_next = S_ERROR;
      else begin
        pc_next    = pc_reg - 1'b1;
        state_next = S_SFETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= '0;
      depth_reg <= '0;
      back_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      back_reg  <= back_next;
    end
  end

  assign exec_op   = (state_reg == S_EXEC) && !is_zero;
  assign imem_addr = pc_reg;
  assign dp_inc    = exec_op & inc_dp;
  assign dp_dec    = exec_op & dec_dp;
  assign d_inc     = exec_op & inc_d;
  assign d_dec     = exec_op & dec_d;
  assign d_load    = (state_reg == S_WAIT_IN) & in_ack;
  assign in_req    = (state_reg == S_WAIT_IN);
  assign out_req   = (state_reg == S_WAIT_OUT);
  assign halted    = (state_reg == S_HALT) | ((state_reg == S_EXEC) & is_zero);
  assign error     = (state_reg == S_ERROR);

endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Random and directed BF programs run through the sequencer and compared
// against a plain BF interpreter that also accounts cycles.
module tb_bf_exec_ctrl;

  localparam logic [7:0] C_INC_DP = 8'h3E, C_DEC_DP = 8'h3C, C_INC_D = 8'h2B,
                         C_DEC_D = 8'h2D, C_OUT = 8'h2E, C_IN = 8'h2C,
                         C_LS = 8'h5B, C_LE = 8'h5D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [11:0] imem_addr;
  logic [7:0]  imem_data;
  logic        inc_dp, dec_dp, inc_d, dec_d, out_d, in_d, loop_start, loop_end, nop;
  logic        d_zero;
  logic        dp_inc, dp_dec, d_inc, d_dec, d_load;
  logic        in_req, out_req, halted, error;
  logic        in_ack = 1'b0;
  logic        out_ack = 1'b0;

  always #5 clk = ~clk;

  bf_exec_ctrl #(.ADDR_W(12), .DEPTH_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
    .inc_dp(inc_dp), .dec_dp(dec_dp), .inc_d(inc_d), .dec_d(dec_d), .out_d(out_d),
    .in_d(in_d), .loop_start(loop_start), .loop_end(loop_end), .nop(nop),
    .d_zero(d_zero), .dp_inc(dp_inc), .dp_dec(dp_dec), .d_inc(d_inc), .d_dec(d_dec),
    .d_load(d_load), .in_req(in_req), .in_ack(in_ack), .out_req(out_req),
    .out_ack(out_ack), .halted(halted), .error(error)
  );

  logic [7:0] mem [0:4095];
  always @(posedge clk) imem_data <= mem[imem_addr];

  always_comb begin
    inc_dp     = (imem_data == C_INC_DP);
    dec_dp     = (imem_data == C_DEC_DP);
    inc_d      = (imem_data == C_INC_D);
    dec_d      = (imem_data == C_DEC_D);
    out_d      = (imem_data == C_OUT);
    in_d       = (imem_data == C_IN);
    loop_start = (imem_data == C_LS);
    loop_end   = (imem_data == C_LE);
    nop        = (imem_data != 8'h00) && !(inc_dp || dec_dp || inc_d || dec_d ||
                                            out_d || in_d || loop_start || loop_end);
  end

  // datapath environment: 16-cell tape driven by the strobes
  logic [7:0] tape [0:15];
  logic [3:0] dp;
  int         in_idx, out_n;
  int         in_vals [0:1023];
  int         in_dly  [0:1023];
  int         out_dly [0:1023];
  logic [7:0] out_log [0:1023];

  assign d_zero = (tape[dp] == 8'h00);

  always @(posedge clk) begin
    if (rst) begin
      dp     <= '0;
      in_idx <= 0;
      out_n  <= 0;
      for (int i = 0; i < 16; i++) tape[i] <= 8'h00;
    end else begin
      if (dp_inc) dp <= dp + 4'd1;
      if (dp_dec) dp <= dp - 4'd1;
      if (d_inc)  tape[dp] <= tape[dp] + 8'd1;
      if (d_dec)  tape[dp] <= tape[dp] - 8'd1;
      if (d_load) begin
        tape[dp] <= in_vals[in_idx][7:0];
        in_idx   <= in_idx + 1;
      end
      if (out_req && out_ack) begin
        out_log[out_n] <= tape[dp];
        out_n          <= out_n + 1;
      end
    end
  end

  // acknowledge after a per-transfer delay; random acks while no request
  int in_cnt = 0, out_cnt = 0;
  always @(negedge clk) begin
    if (in_req) begin
      in_cnt = in_cnt + 1;
      in_ack = (in_cnt == in_dly[in_idx]);
    end else begin
      in_cnt = 0;
      in_ack = 1'($urandom_range(0, 1));
    end
    if (out_req) begin
      out_cnt = out_cnt + 1;
      out_ack = (out_cnt == out_dly[out_n]);
    end else begin
      out_cnt = 0;
      out_ack = 1'($urandom_range(0, 1));
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference interpreter
  int         exp_t, exp_pc, exp_on;
  logic       exp_halt, exp_err;
  logic [3:0] exp_dp;
  logic [7:0] exp_tape [0:15];
  logic [7:0] exp_out  [0:1023];

  task automatic model();
    int pc, t, ii, oi, p, depth, steps;
    logic [7:0] c;
    logic [3:0] mdp;
    logic found;
    for (int i = 0; i < 16; i++) exp_tape[i] = 8'h00;
    pc = 0; t = 0; ii = 0; oi = 0; mdp = '0; steps = 0;
    exp_halt = 1'b0; exp_err = 1'b0;
    while (!exp_halt && !exp_err && steps < 200000) begin
      steps++;
      c = mem[pc];
      t += 2;
      if (c == 8'h00) exp_halt = 1'b1;
      else if (c == C_INC_DP) begin mdp++; pc++; end
      else if (c == C_DEC_DP) begin mdp--; pc++; end
      else if (c == C_INC_D) begin exp_tape[mdp]++; pc++; end
      else if (c == C_DEC_D) begin exp_tape[mdp]--; pc++; end
      else if (c == C_IN) begin
        exp_tape[mdp] = in_vals[ii][7:0]; t += in_dly[ii]; ii++; pc++;
      end else if (c == C_OUT) begin
        exp_out[oi] = exp_tape[mdp]; t += out_dly[oi]; oi++; pc++;
      end else if (c == C_LS && exp_tape[mdp] == 0) begin
        p = pc; depth = 0; found = 1'b0;
        while (!found && !exp_err) begin
          p++; t += 2; c = mem[p];
          if (c == 8'h00) exp_err = 1'b1;
          else if (c == C_LS) depth++;
          else if (c == C_LE) begin
            if (depth == 0) found = 1'b1; else depth--;
          end
        end
        pc = p + 1;
      end else if (c == C_LE && exp_tape[mdp] != 0) begin
        p = pc; depth = 0; found = 1'b0;
        while (!found && !exp_err) begin
          if (p == 0) exp_err = 1'b1;
          else begin
            p--; t += 2; c = mem[p];
            if (c == C_LE) depth++;
            else if (c == C_LS) begin
              if (depth == 0) found = 1'b1; else depth--;
            end
          end
        end
        pc = p + 1;
      end else pc++;
    end
    exp_t = t; exp_pc = pc; exp_dp = mdp; exp_on = oi;
  endtask

  task automatic load(input string prog, input int fixed_dly);
    for (int i = 0; i < 4096; i++) mem[i] = (i < prog.len()) ? prog[i] : 8'h00;
    for (int i = 0; i < 1024; i++) begin
      in_vals[i] = $urandom_range(0, 3);
      in_dly[i]  = (fixed_dly != 0) ? fixed_dly : $urandom_range(1, 4);
      out_dly[i] = (fixed_dly != 0) ? fixed_dly : $urandom_range(1, 4);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; run = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_prog(input string prog, input int pause, input int fixed_dly,
                          input string name, output int cyc);
    load(prog, fixed_dly);
    model();
    do_reset();
    cyc = 0;
    forever begin
      run = (cyc >= pause);
      if (halted || error || cyc >= 20000) break;
      @(negedge clk);
      cyc++;
    end
    check({name, "_timeout"}, 32'(cyc >= 20000), 0);
    check({name, "_halted"}, 32'(halted), 32'(exp_halt));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    if (exp_halt) begin
      check({name, "_cycles"}, cyc, exp_t - 1 + pause);
      check({name, "_pc"}, 32'(imem_addr), exp_pc);
    end
    check({name, "_dp"}, 32'(dp), 32'(exp_dp));
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_cell%0d", name, i), 32'(tape[i]), 32'(exp_tape[i]));
    check({name, "_outs"}, out_n, exp_on);
    for (int i = 0; i < exp_on && i < out_n; i++)
      check($sformatf("%s_out%0d", name, i), 32'(out_log[i]), 32'(exp_out[i]));
    $display("prog %s len=%0d cycles=%0d halted=%0d error=%0d outs=%0d",
             name, prog.len(), cyc, halted, error, out_n);
  endtask

  task automatic rst_mid(input string prog, input int n, input int pre_pc,
                         input logic pre_req, input string name);
    load(prog, 1000);
    do_reset();
    run = 1'b1;
    repeat (n) @(negedge clk);
    check({name, "_pre_pc"}, 32'(imem_addr), pre_pc);
    check({name, "_pre_req"}, 32'(in_req), 32'(pre_req));
    rst = 1'b1;
    @(negedge clk);
    check({name, "_rst_pc"}, 32'(imem_addr), 0);
    check({name, "_rst_outs"}, 32'({dp_inc, dp_dec, d_inc, d_dec, d_load, in_req,
                                    out_req, halted, error}), 0);
    rst = 1'b0;
    @(negedge clk);
    check({name, "_post_outs"}, 32'({dp_inc, dp_dec, d_inc, d_dec, d_load, in_req,
                                     out_req, halted, error}), 0);
    $display("reset %s after %0d cycles pc=%0d", name, n, imem_addr);
  endtask

  string frags [0:9] = '{"+", ">", "<", ".", ",", "[-]", "[>+<-]", "[[-]]", "[.-]", "+-"};

  initial begin
    int c;
    string s;
    do_reset();
    check("reset_pc", 32'(imem_addr), 0);
    check("reset_outs", 32'({dp_inc, dp_dec, d_inc, d_dec, d_load, in_req, out_req,
                             halted, error}), 0);

    run_prog("+>-<", 0, 0, "t1", c);
    check("t1_halt_cycle", c, 9);
    run_prog(".", 0, 3, "t2", c);
    check("t2_cycles", c, 6);
    run_prog("[+]", 0, 0, "t3", c);
    check("t3_halt_cycle", c, 7);
    run_prog("++[-]", 0, 0, "t4", c);
    run_prog("[[]+]", 0, 0, "t5a", c);
    check("t5a_pc", 32'(imem_addr), 5);
    run_prog("[+", 0, 0, "t5b", c);
    run_prog("+]", 0, 0, "unmatched_back", c);
    run_prog("+>+.<.", 4, 0, "pause", c);
    rst_mid("[+++]", 3, 1, 1'b0, "t6_scan");
    rst_mid(",+", 2, 0, 1'b1, "t6_wait_in");

    for (int k = 0; k < 10; k++) begin
      s = "";
      for (int j = 0; j < 12; j++) s = {s, frags[$urandom_range(0, 9)]};
      run_prog(s, $urandom_range(0, 2), 0, $sformatf("rnd%0d", k), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
